// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
//   arb_state_t : arbiter FSM state (idle arbitration / grant locked for a packet)
//   rr_pick     : first set bit of valid at or after ptr, wrapping at n
package mux_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Widest requester vector rr_pick accepts; callers zero-extend into it.
  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxReqW = 5;

  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      // ptr < n and k < n, so a single subtraction completes the wrap.
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && valid[idx[MaxReqW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_nto1_word.sv
// Combinational N:1 word multiplexer.
//   data_i : N words packed, word i at [i*WIDTH +: WIDTH]
//   sel_i  : index of the word to forward (out-of-range selects zero)
//   data_o : selected word
module mux_nto1_word #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_i == SEL_W'(i)) data_o = data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter sharing one WIDTH-bit channel between N_REQ requesters.
// A grant is locked from the first beat until the beat carrying last has transferred;
// beats go through an N:1 mux into a one-entry valid/ready output register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/last/data : per-requester beat stream (requester i data at [i*WIDTH +: WIDTH])
//   req_ready           : per-requester accept, only the granted bit can be set
//   out_valid/data/last : registered output beat
//   out_sel             : requester index that sourced the output beat
//   out_ready           : downstream accept
//   busy                : grant is locked
module rr_mux_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready,
  output logic                   busy
);
  import mux_arb_pkg::*;

  if (N_REQ < 2 || N_REQ > MaxReq) begin : g_bad_n_req
    $error("rr_mux_arbiter: N_REQ must be in 2..32");
  end

  // Each mux word carries {last, data} so one mux serves both.
  localparam int unsigned BW = WIDTH + 1;

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] gnt_q, gnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [N_REQ*BW-1:0] beat_bus;
  logic [BW-1:0]       sel_beat;
  logic                accept;
  logic                xfer;

  for (genvar i = 0; i < N_REQ; i++) begin : g_pack
    assign beat_bus[i*BW +: BW] = {req_last[i], req_data[i*WIDTH +: WIDTH]};
  end

  mux_nto1_word #(
    .N     (N_REQ),
    .WIDTH (BW)
  ) u_mux (
    .data_i (beat_bus),
    .sel_i  (gnt_q),
    .data_o (sel_beat)
  );

  // req_ready is a function of registered state and out_ready only, never of req_valid.
  assign accept = !out_valid_q || out_ready;

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_LOCKED) req_ready[gnt_q] = accept;
  end

  assign xfer = req_ready[gnt_q] && req_valid[gnt_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (|req_valid) begin
          gnt_d   = SEL_W'(rr_pick(MaxReq'(req_valid), int'(ptr_q), N_REQ));
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (xfer && sel_beat[WIDTH]) begin
          state_d = ARB_IDLE;
          ptr_d   = (gnt_q == SEL_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // A load wins over a drain, giving back-to-back beats at full rate.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_beat[WIDTH-1:0];
      out_last_d  = sel_beat[WIDTH];
      out_sel_d   = gnt_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == ARB_LOCKED);

endmodule
